// File: rtl/rf_wb_arb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package rf_wb_arb_pkg;

   localparam int RF_AW = 5;
   localparam int XLEN  = 64;

   typedef logic [RF_AW-1:0] reg_idx_t;

   // Width of an index into n requesters; never zero so a single requester still builds.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rf_wb_arb_rr_arb.sv
// Combinational round-robin grant: first requester at or after ptr (modulo N) wins.
module rr_arb #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic found;
   int   idx;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, otherwise a path that skips the assignment infers a latch.
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arb.sv
// Write-back arbiter: grants one requester per cycle, registers the RF write, tracks pending destinations.
// Define WB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module rf_wb_arb
   import rf_wb_arb_pkg::ptr_w;
   import rf_wb_arb_pkg::RF_AW;
#(
   parameter int NREQ = 3,
   parameter int XLEN = rf_wb_arb_pkg::XLEN,
   parameter int AW   = RF_AW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*XLEN-1:0] req_data,
   input  logic                 alloc_valid,
   input  logic [AW-1:0]        alloc_addr,
   output logic                 rf_wen,
   output logic [AW-1:0]        rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
   output logic [2**AW-1:0]     pending
);

   localparam int PW = ptr_w(NREQ);
   localparam int NR = 2**AW;

   logic [NREQ-1:0] gnt;
   logic            xfer;
   logic [AW-1:0]   g_addr;
   logic [XLEN-1:0] g_data;
   logic [NR-1:1]   pend_q;
   logic [NR-1:1]   set_m;
   logic [NR-1:1]   clr_m;

`ifdef WB_ARB_FIXED_PRIO_EN
   rr_arb #(.N(NREQ), .PW(PW)) u_arb (
      .req (req_valid),
      .ptr ({PW{1'b0}}),
      .gnt (gnt)
   );
`else
   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;

   rr_arb #(.N(NREQ), .PW(PW)) u_arb (
      .req (req_valid),
      .ptr (ptr),
      .gnt (gnt)
   );

   always_comb begin
      ptr_nxt = ptr;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) ptr <= '0;
      else     ptr <= ptr_nxt;
   end
`endif

   // Grants always come from valid requesters, so any grant outside reset is a transfer.
   assign req_ready = gnt & {NREQ{~rst}};
   assign xfer      = |req_ready;

   always_comb begin
      g_addr = '0;
      g_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            g_addr = req_addr[i*AW +: AW];
            g_data = req_data[i*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_wen <= xfer && (g_addr != '0);
         if (xfer) begin
            rf_waddr <= g_addr;
            rf_wdata <= g_data;
         end
      end
   end

   always_comb begin
      set_m = '0;
      clr_m = '0;
      for (int r = 1; r < NR; r++) begin
         if (alloc_valid && alloc_addr == AW'(r)) set_m[r] = 1'b1;
         if (xfer && g_addr == AW'(r))            clr_m[r] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the scoreboard is reset as a whole; a stale pending bit after reset would stall issue forever.
      if (rst) pend_q <= '0;
      else     pend_q <= (pend_q & ~clr_m) | set_m;
   end

   assign pending = {pend_q, 1'b0};

endmodule
